// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory stage: access sizes, FSM states
// and alignment helpers.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  // An access is misaligned when any address bit below its natural size is set.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic res;
    case (size)
      SIZE_B:  res = 1'b0;
      SIZE_H:  res = off[0];
      SIZE_W:  res = |off[1:0];
      default: res = |off;
    endcase
    return res;
  endfunction

  function automatic int unsigned size_bytes(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Rotates the bus word so the addressed lane lands at bit 0, then sign- or
// zero-extends the selected byte/half/word to the full datapath width.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] offset,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  data
);

  logic [OFF_W+2:0] shamt;
  logic [XLEN-1:0]  rot;
  logic [XLEN-1:0]  keep;
  logic             fill;

  assign shamt = {offset, 3'b000};

  // Lanes past the top of the word wrap around to lane 0.
  always_comb begin
    rot  = (rdata >> shamt) | (rdata << (XLEN - shamt));
    keep = {XLEN{1'b1}};
    fill = 1'b0;
    case (funct3[1:0])
      SIZE_B: begin
        keep = XLEN'(8'hFF);
        fill = rot[7];
      end
      SIZE_H: begin
        keep = XLEN'(16'hFFFF);
        fill = rot[15];
      end
      SIZE_W: begin
        keep = XLEN'(32'hFFFF_FFFF);
        fill = rot[31];
      end
      default: begin
        keep = {XLEN{1'b1}};
        fill = rot[XLEN-1];
      end
    endcase
    if (funct3[2]) begin
      fill = 1'b0;
    end
    data = (rot & keep) | (fill ? ~keep : '0);
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory pipeline stage with a req/gnt/rvalid data bus, byte-enable stores and
// aligned loads. Optional MEM_MISALIGN_TRAP_EN suppresses misaligned accesses.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic              mem_op_i,
  input  logic              mem_we_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   fu_i,
  input  logic [XLEN-1:0]   sdata_i,
  input  logic [XLEN-1:0]   pcplus_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic              rf_we_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [XLEN/8-1:0] dbus_be_o,
  output logic [XLEN-1:0]   dbus_wdata_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [XLEN-1:0]   dbus_rdata_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [XLEN-1:0]   wb_fu_o,
  output logic [XLEN-1:0]   wb_mem_o,
  output logic [XLEN-1:0]   wb_pcplus_o,
  output logic [RD_W-1:0]   wb_rd_o,
  output logic              wb_we_o,
  output logic [CTRL_W-1:0] wb_ctrl_o,
  output logic [RD_W-1:0]   rd_mem_o,
  output logic              we_mem_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              wb_exc_o
`endif
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  lsu_state_e state_q, state_d;
  logic       ready;
  logic       accept;
  logic       trap;

  logic [OFF_W-1:0]  off;
  logic [OFF_W+2:0]  shamt;
  logic [BE_W-1:0]   be_base;
  logic [BE_W-1:0]   be_new;
  logic [XLEN-1:0]   rep;
  logic [XLEN-1:0]   wdata_new;
  logic [ADDR_W-1:0] addr_new;

  logic              st_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   fu_q;
  logic [XLEN-1:0]   pc_q;
  logic [RD_W-1:0]   rd_q;
  logic              we_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   mem_q;
  logic [XLEN-1:0]   load_data;

  assign off      = fu_i[OFF_W-1:0];
  assign shamt    = {off, 3'b000};
  assign addr_new = {fu_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = mem_op_i & misaligned(funct3_i[1:0], 3'(off));
`else
  assign trap = 1'b0;
`endif

  // Store data is replicated per size, then rotated so misaligned lanes wrap
  // inside the word with the low byte landing on the addressed lane.
  always_comb begin
    be_base = '1;
    rep     = sdata_i;
    case (funct3_i[1:0])
      SIZE_B: begin
        be_base = BE_W'(1);
        rep     = {BE_W{sdata_i[7:0]}};
      end
      SIZE_H: begin
        be_base = BE_W'(3);
        rep     = {(BE_W/2){sdata_i[15:0]}};
      end
      SIZE_W: begin
        be_base = BE_W'(15);
        rep     = {(BE_W/4){sdata_i[31:0]}};
      end
      default: begin
        be_base = '1;
        rep     = sdata_i;
      end
    endcase
    be_new    = (be_base << off) | (be_base >> (BE_W - off));
    wdata_new = (rep << shamt) | (rep >> (XLEN - shamt));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accepting in RESP while WB drains lets ops flow back-to-back.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: ready = 1'b1;
      REQ: begin
        if (dbus_gnt_i) begin
          state_d = st_q ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (dbus_rvalid_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (wb_ready_i) begin
          ready   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    accept = ex_valid_i & ready;
    if (accept) begin
      state_d = (mem_op_i & ~trap) ? REQ : RESP;
    end
  end

  lsu_load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_align (
    .rdata  (dbus_rdata_i),
    .offset (fu_q[OFF_W-1:0]),
    .funct3 (f3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= 1'b0;
      f3_q    <= '0;
      fu_q    <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      ctrl_q  <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      mem_q   <= '0;
    end else if (accept) begin
      st_q    <= mem_we_i;
      f3_q    <= funct3_i;
      fu_q    <= fu_i;
      pc_q    <= pcplus_i;
      rd_q    <= rd_i;
      we_q    <= rf_we_i & ~trap;
      ctrl_q  <= ctrl_i;
      addr_q  <= addr_new;
      be_q    <= be_new;
      wdata_q <= wdata_new;
      mem_q   <= '0;
    end else if (state_q == WAIT && dbus_rvalid_i) begin
      mem_q   <= load_data;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic exc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_q <= 1'b0;
    end else if (accept) begin
      exc_q <= trap;
    end
  end

  assign wb_exc_o = exc_q;
`endif

  assign ex_ready_o   = ready;
  assign dbus_req_o   = (state_q == REQ);
  assign dbus_we_o    = dbus_req_o & st_q;
  assign dbus_addr_o  = dbus_req_o ? addr_q : '0;
  assign dbus_be_o    = dbus_req_o ? be_q : '0;
  assign dbus_wdata_o = (dbus_req_o & st_q) ? wdata_q : '0;

  assign wb_valid_o  = (state_q == RESP);
  assign wb_fu_o     = fu_q;
  assign wb_mem_o    = mem_q;
  assign wb_pcplus_o = pc_q;
  assign wb_rd_o     = rd_q;
  assign wb_we_o     = we_q;
  assign wb_ctrl_o   = ctrl_q;

  assign rd_mem_o = (state_q != IDLE) ? rd_q : '0;
  assign we_mem_o = (state_q != IDLE) & we_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: expected WB results are queued at issue
// and compared as WB handshakes complete; bus-side checks are made inline.
module tb_mem_stage_lsu;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 8;

  logic              clk;
  logic              rst_n;
  logic              ex_valid_i;
  logic              ex_ready_o;
  logic              mem_op_i;
  logic              mem_we_i;
  logic [2:0]        funct3_i;
  logic [XLEN-1:0]   fu_i;
  logic [XLEN-1:0]   sdata_i;
  logic [XLEN-1:0]   pcplus_i;
  logic [RD_W-1:0]   rd_i;
  logic              rf_we_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              dbus_req_o;
  logic              dbus_we_o;
  logic [ADDR_W-1:0] dbus_addr_o;
  logic [XLEN/8-1:0] dbus_be_o;
  logic [XLEN-1:0]   dbus_wdata_o;
  logic              dbus_gnt_i;
  logic              dbus_rvalid_i;
  logic [XLEN-1:0]   dbus_rdata_i;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [XLEN-1:0]   wb_fu_o;
  logic [XLEN-1:0]   wb_mem_o;
  logic [XLEN-1:0]   wb_pcplus_o;
  logic [RD_W-1:0]   wb_rd_o;
  logic              wb_we_o;
  logic [CTRL_W-1:0] wb_ctrl_o;
  logic [RD_W-1:0]   rd_mem_o;
  logic              we_mem_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              wb_exc_o;
`endif

  typedef struct {
    logic [31:0] fu;
    logic [31:0] mem;
    logic [31:0] pcplus;
    logic [4:0]  rd;
    logic        we;
    logic [7:0]  ctrl;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  mem_stage_lsu #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W),
    .RD_W   (RD_W),
    .CTRL_W (CTRL_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid_i    (ex_valid_i),
    .ex_ready_o    (ex_ready_o),
    .mem_op_i      (mem_op_i),
    .mem_we_i      (mem_we_i),
    .funct3_i      (funct3_i),
    .fu_i          (fu_i),
    .sdata_i       (sdata_i),
    .pcplus_i      (pcplus_i),
    .rd_i          (rd_i),
    .rf_we_i       (rf_we_i),
    .ctrl_i        (ctrl_i),
    .dbus_req_o    (dbus_req_o),
    .dbus_we_o     (dbus_we_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_be_o     (dbus_be_o),
    .dbus_wdata_o  (dbus_wdata_o),
    .dbus_gnt_i    (dbus_gnt_i),
    .dbus_rvalid_i (dbus_rvalid_i),
    .dbus_rdata_i  (dbus_rdata_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .wb_fu_o       (wb_fu_o),
    .wb_mem_o      (wb_mem_o),
    .wb_pcplus_o   (wb_pcplus_o),
    .wb_rd_o       (wb_rd_o),
    .wb_we_o       (wb_we_o),
    .wb_ctrl_o     (wb_ctrl_o),
    .rd_mem_o      (rd_mem_o),
    .we_mem_o      (we_mem_o)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .wb_exc_o      (wb_exc_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Inputs change on the falling edge; everything is sampled shortly after.
  task automatic cycle();
    @(negedge clk);
    ex_valid_i    = 1'b0;
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b0;
  endtask

  task automatic applyStimulus(input logic mem_op, input logic we, input logic [2:0] f3,
                               input logic [31:0] fu, input logic [31:0] sdata,
                               input logic [4:0] rd, input logic rf_we,
                               input logic push, input logic [31:0] exp_mem);
    exp_t e;
    ex_valid_i = 1'b1;
    mem_op_i   = mem_op;
    mem_we_i   = we;
    funct3_i   = f3;
    fu_i       = fu;
    sdata_i    = sdata;
    pcplus_i   = fu + 32'h4;
    rd_i       = rd;
    rf_we_i    = rf_we;
    ctrl_i     = {3'b101, rd};
    #1;
    checkOutput("ex_ready_issue", ex_ready_o, 1);
    if (push) begin
      e.fu     = fu;
      e.mem    = exp_mem;
      e.pcplus = fu + 32'h4;
      e.rd     = rd;
      e.we     = rf_we;
      e.ctrl   = {3'b101, rd};
      sb_q.push_back(e);
    end
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                          input int gnt_wait, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_addr);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, f3, addr, sdata, 5'd0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i <= gnt_wait; i++) begin
      cycle();
      dbus_gnt_i = (i == gnt_wait);
      #1;
      checkOutput("st_req", dbus_req_o, 1);
      checkOutput("st_we", dbus_we_o, 1);
      checkOutput("st_addr", dbus_addr_o, exp_addr);
      checkOutput("st_be", dbus_be_o, exp_be);
      checkOutput("st_wdata", dbus_wdata_o, exp_wdata);
      checkOutput("st_ex_ready", ex_ready_o, 0);
    end
    cycle();
    #1;
    checkOutput("st_req_done", dbus_req_o, 0);
    checkOutput("st_wb_valid", wb_valid_o, 1);
    checkOutput("st_ex_ready_resp", ex_ready_o, 1);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_mem);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, f3, addr, 32'h0, rd, 1'b1, 1'b1, exp_mem);
    cycle();
    dbus_gnt_i = 1'b1;
    #1;
    checkOutput("ld_req", dbus_req_o, 1);
    checkOutput("ld_we", dbus_we_o, 0);
    checkOutput("ld_addr", dbus_addr_o, exp_addr);
    checkOutput("ld_be", dbus_be_o, exp_be);
    checkOutput("ld_rd_mem", rd_mem_o, rd);
    checkOutput("ld_we_mem", we_mem_o, 1);
    cycle();
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = rdata;
    #1;
    checkOutput("ld_wait_req", dbus_req_o, 0);
    checkOutput("ld_wait_valid", wb_valid_o, 0);
    cycle();
    #1;
    checkOutput("ld_wb_valid", wb_valid_o, 1);
    checkOutput("ld_wb_mem", wb_mem_o, exp_mem);
  endtask

  // WB monitor: every completed handshake must match the oldest queued op.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && wb_valid_o && wb_ready_i) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_unexpected_wb", 1, 0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("sb_fu", wb_fu_o, e.fu);
        checkOutput("sb_mem", wb_mem_o, e.mem);
        checkOutput("sb_pcplus", wb_pcplus_o, e.pcplus);
        checkOutput("sb_rd", wb_rd_o, e.rd);
        checkOutput("sb_we", wb_we_o, e.we);
        checkOutput("sb_ctrl", wb_ctrl_o, e.ctrl);
      end
    end
  end

  initial begin
    exp_t e;
    rst_n         = 1'b0;
    ex_valid_i    = 1'b0;
    mem_op_i      = 1'b0;
    mem_we_i      = 1'b0;
    funct3_i      = 3'b000;
    fu_i          = '0;
    sdata_i       = '0;
    pcplus_i      = '0;
    rd_i          = '0;
    rf_we_i       = 1'b0;
    ctrl_i        = '0;
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b0;
    dbus_rdata_i  = '0;
    wb_ready_i    = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_wb_valid", wb_valid_o, 0);
    checkOutput("rst_req", dbus_req_o, 0);
    checkOutput("rst_be", dbus_be_o, 0);
    checkOutput("rst_wb_fu", wb_fu_o, 0);
    checkOutput("rst_rd_mem", rd_mem_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU pass-through: one cycle, no bus activity
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b1, 32'h0);
    checkOutput("alu_no_req", dbus_req_o, 0);
    cycle();
    #1;
    checkOutput("alu_wb_valid", wb_valid_o, 1);
    checkOutput("alu_wb_fu", wb_fu_o, 32'h1234);
    checkOutput("alu_req_idle", dbus_req_o, 0);

    // Stores: lane enables and replicated data
    do_store(3'b000, 32'h103, 32'h0000_00AB, 2, 4'b1000, 32'hABAB_ABAB, 32'h100);
    do_store(3'b001, 32'h102, 32'h0000_CAFE, 0, 4'b1100, 32'hCAFE_CAFE, 32'h100);
    do_store(3'b010, 32'h200, 32'h1122_3344, 1, 4'b1111, 32'h1122_3344, 32'h200);

    // Loads: lane select with sign and zero extension
    do_load(3'b001, 32'h102, 32'h8001_0000, 5'd7, 32'h100, 4'b1100, 32'hFFFF_8001);
    do_load(3'b101, 32'h102, 32'h8001_0000, 5'd8, 32'h100, 4'b1100, 32'h0000_8001);
    do_load(3'b000, 32'h101, 32'h0000_8000, 5'd10, 32'h100, 4'b0010, 32'hFFFF_FF80);
    do_load(3'b100, 32'h303, 32'h7F00_0000, 5'd11, 32'h300, 4'b1000, 32'h0000_007F);

    // Reset while a load waits for data: the late rvalid must be dropped
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd9, 1'b1, 1'b0, 32'h0);
    cycle();
    dbus_gnt_i = 1'b1;
    cycle();
    #1;
    checkOutput("wait_rd_mem", rd_mem_o, 9);
    checkOutput("wait_we_mem", we_mem_o, 1);
    checkOutput("wait_wb_valid", wb_valid_o, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_wb_valid", wb_valid_o, 0);
    checkOutput("arst_req", dbus_req_o, 0);
    checkOutput("arst_rd_mem", rd_mem_o, 0);
    checkOutput("arst_we_mem", we_mem_o, 0);
    checkOutput("arst_wb_fu", wb_fu_o, 0);
    checkOutput("arst_wb_we", wb_we_o, 0);
    cycle();
    rst_n         = 1'b1;
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'hDEAD_BEEF;
    cycle();
    #1;
    checkOutput("post_rst_wb_valid", wb_valid_o, 0);
    checkOutput("post_rst_wb_mem", wb_mem_o, 0);
    checkOutput("post_rst_req", dbus_req_o, 0);

    // WB backpressure holds the result, then releases into a back-to-back op
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h55, 32'h0, 5'd3, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      wb_ready_i = 1'b0;
      #1;
      checkOutput("stall_wb_valid", wb_valid_o, 1);
      checkOutput("stall_wb_fu", wb_fu_o, 32'h55);
      checkOutput("stall_ex_ready", ex_ready_o, 0);
    end
    cycle();
    wb_ready_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h66, 32'h0, 5'd4, 1'b1, 1'b1, 32'h0);
    checkOutput("b2b_old_fu", wb_fu_o, 32'h55);
    cycle();
    #1;
    checkOutput("b2b_wb_valid", wb_valid_o, 1);
    checkOutput("b2b_wb_fu", wb_fu_o, 32'h66);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned word load never reaches the bus and retires as an exception
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd6, 1'b1, 1'b0, 32'h0);
    e.fu     = 32'h101;
    e.mem    = 32'h0;
    e.pcplus = 32'h105;
    e.rd     = 5'd6;
    e.we     = 1'b0;
    e.ctrl   = {3'b101, 5'd6};
    sb_q.push_back(e);
    cycle();
    #1;
    checkOutput("trap_req", dbus_req_o, 0);
    checkOutput("trap_wb_valid", wb_valid_o, 1);
    checkOutput("trap_exc", wb_exc_o, 1);
    checkOutput("trap_wb_we", wb_we_o, 0);
`else
    // Misaligned accesses go out with lanes wrapped inside the word
    do_load(3'b010, 32'h101, 32'h4433_2211, 5'd6, 32'h100, 4'b1111, 32'h1144_3322);
    do_store(3'b001, 32'h103, 32'h0000_CAFE, 0, 4'b1001, 32'hFECA_FECA, 32'h100);
`endif

    repeat (2) @(negedge clk);
    #3;
    checkOutput("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
